// File: rtl/pc_sequencer_if.sv
// Signal bundle between the next-PC sequencer and its neighbours
// (hazard unit, EX branch resolution, CSR unit, PC register).
interface pc_sequencer_if;
    localparam int unsigned XLEN = 32;

    logic            stall;
    logic [XLEN-1:0] pc;
    logic            br_taken;
    logic [XLEN-1:0] br_target;
    logic            mret_req;
    logic [XLEN-1:0] mepc;
    logic            trap_req;
    logic [XLEN-1:0] mtvec;
    logic            csr_ack;
    logic [XLEN-1:0] next_pc;
    logic            pc_write;
    logic            flush;
    logic            trap_start;
    logic            busy;

    modport master (
        input  stall, pc, br_taken, br_target, mret_req, mepc,
               trap_req, mtvec, csr_ack,
        output next_pc, pc_write, flush, trap_start, busy
    );

    modport slave (
        output stall, pc, br_taken, br_target, mret_req, mepc,
               trap_req, mtvec, csr_ack,
        input  next_pc, pc_write, flush, trap_start, busy
    );
endinterface

// File: rtl/pc_sequencer.sv
// Next-PC controller: selects sequential/branch/mret/trap-vector PC, owns
// front-end flushes and the two-phase trap-entry handshake with the CSR unit.
module pc_sequencer #(
    parameter logic [31:0] RESET_VEC = 32'h0000_0000
) (
    input  logic                 clk,
    input  logic                 reset,
    pc_sequencer_if.master       bus
);
    localparam int unsigned XLEN = 32;
    localparam logic [XLEN-1:0] ALIGN_MASK = 32'hFFFF_FFFC;

    typedef enum logic [1:0] {
        RUN       = 2'd0,
        HOLD      = 2'd1,
        TRAP_WAIT = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [XLEN-1:0] pend_q, pend_d;
    logic [XLEN-1:0] seq_pc;
    logic [XLEN-1:0] redir_tgt;

    assign seq_pc    = bus.pc + XLEN'(4);
    // mret outranks a same-cycle branch
    assign redir_tgt = (bus.mret_req ? bus.mepc : bus.br_target) & ALIGN_MASK;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= RUN;
            pend_q  <= '0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        pend_d         = pend_q;
        bus.next_pc    = seq_pc;
        bus.pc_write   = 1'b0;
        bus.flush      = 1'b0;
        bus.trap_start = 1'b0;
        bus.busy       = (state_q != RUN);

        if (reset) begin
            bus.next_pc = RESET_VEC;
            bus.busy    = 1'b0;
            state_d     = RUN;
            pend_d      = '0;
        end else begin
            unique case (state_q)
                RUN, HOLD: begin
                    if (bus.trap_req) begin
                        // Trap wins regardless of stall; any pending redirect is dropped
                        bus.trap_start = 1'b1;
                        bus.flush      = 1'b1;
                        pend_d         = '0;
                        state_d        = TRAP_WAIT;
                    end else if (bus.mret_req || bus.br_taken) begin
                        bus.flush = 1'b1;
                        if (bus.stall) begin
                            pend_d  = redir_tgt;
                            state_d = HOLD;
                        end else begin
                            bus.next_pc  = redir_tgt;
                            bus.pc_write = 1'b1;
                            state_d      = RUN;
                        end
                    end else if (state_q == HOLD) begin
                        if (!bus.stall) begin
                            bus.next_pc  = pend_q;
                            bus.pc_write = 1'b1;
                            state_d      = RUN;
                        end
                    end else begin
                        bus.pc_write = ~bus.stall;
                    end
                end
                TRAP_WAIT: begin
                    bus.flush = 1'b1;
                    if (bus.csr_ack) begin
                        bus.next_pc  = bus.mtvec & ALIGN_MASK;
                        bus.pc_write = 1'b1;
                        state_d      = RUN;
                    end
                end
                default: begin
                    state_d = RUN;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_pc_sequencer.sv
// Directed-vector bench for pc_sequencer; each vector checks
// {next_pc, pc_write, flush, trap_start, busy} against hand-computed values.
module tb_pc_sequencer;
    logic clk;
    logic reset;
    int   vectors;
    int   errors;
    logic [35:0] obs;
    logic [35:0] exp_v;

    pc_sequencer_if bus ();

    pc_sequencer #(.RESET_VEC(32'h0000_0000)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic idle();
        bus.stall     = 1'b0;
        bus.br_taken  = 1'b0;
        bus.br_target = 32'h0;
        bus.mret_req  = 1'b0;
        bus.mepc      = 32'h0;
        bus.trap_req  = 1'b0;
        bus.mtvec     = 32'h0;
        bus.csr_ack   = 1'b0;
    endtask

    // Advance one cycle; inputs are driven and outputs sampled mid-low-phase
    task automatic tick();
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1; idle();
        bus.pc = 32'h0000_1234; bus.trap_req = 1'b1; bus.br_taken = 1'b1;
        tick(); tick(); #1;
        obs = {bus.next_pc, bus.pc_write, bus.flush, bus.trap_start, bus.busy};
        exp_v = {32'h0000_0000, 1'b0, 1'b0, 1'b0, 1'b0};
        vectors++;
        if (obs !== exp_v) begin errors++; $display("FAIL reset_outputs got=%h want=%h", obs, exp_v); end
        tick();
        reset = 1'b0; idle();
    endtask

    task automatic test_sequential();
        for (int i = 0; i < 4; i++) begin
            bus.pc = 32'(i * 4); #1;
            obs = {bus.next_pc, bus.pc_write, bus.flush, bus.trap_start, bus.busy};
            exp_v = {32'(i * 4 + 4), 1'b1, 1'b0, 1'b0, 1'b0};
            vectors++;
            if (obs !== exp_v) begin errors++; $display("FAIL seq_%0d got=%h want=%h", i, obs, exp_v); end
            tick();
        end
        bus.pc = 32'hFFFF_FFFC; #1;
        obs = {bus.next_pc, bus.pc_write, bus.flush, bus.trap_start, bus.busy};
        exp_v = {32'h0000_0000, 1'b1, 1'b0, 1'b0, 1'b0};
        vectors++;
        if (obs !== exp_v) begin errors++; $display("FAIL seq_wrap got=%h want=%h", obs, exp_v); end
        tick();
        bus.pc = 32'h0000_0010; bus.stall = 1'b1; bus.csr_ack = 1'b1; #1;
        obs = {bus.next_pc, bus.pc_write, bus.flush, bus.trap_start, bus.busy};
        exp_v = {32'h0000_0014, 1'b0, 1'b0, 1'b0, 1'b0};
        vectors++;
        if (obs !== exp_v) begin errors++; $display("FAIL seq_stall got=%h want=%h", obs, exp_v); end
        tick(); idle();
    endtask

    task automatic test_branch();
        bus.pc = 32'h0000_0020; bus.br_taken = 1'b1; bus.br_target = 32'h0000_0103; #1;
        obs = {bus.next_pc, bus.pc_write, bus.flush, bus.trap_start, bus.busy};
        exp_v = {32'h0000_0100, 1'b1, 1'b1, 1'b0, 1'b0};
        vectors++;
        if (obs !== exp_v) begin errors++; $display("FAIL branch_take got=%h want=%h", obs, exp_v); end
        tick(); idle();
        bus.pc = 32'h0000_0100; #1;
        obs = {bus.next_pc, bus.pc_write, bus.flush, bus.trap_start, bus.busy};
        exp_v = {32'h0000_0104, 1'b1, 1'b0, 1'b0, 1'b0};
        vectors++;
        if (obs !== exp_v) begin errors++; $display("FAIL branch_resume got=%h want=%h", obs, exp_v); end
        tick();
    endtask

    task automatic test_branch_stall();
        bus.pc = 32'h0000_0050; bus.stall = 1'b1;
        bus.br_taken = 1'b1; bus.br_target = 32'h0000_0302; #1;
        obs = {bus.next_pc, bus.pc_write, bus.flush, bus.trap_start, bus.busy};
        exp_v = {32'h0000_0054, 1'b0, 1'b1, 1'b0, 1'b0};
        vectors++;
        if (obs !== exp_v) begin errors++; $display("FAIL stall_br_first got=%h want=%h", obs, exp_v); end
        tick();
        bus.br_taken = 1'b0; bus.br_target = 32'h0000_0900;
        for (int i = 0; i < 2; i++) begin
            #1;
            obs = {bus.next_pc, bus.pc_write, bus.flush, bus.trap_start, bus.busy};
            exp_v = {32'h0000_0054, 1'b0, 1'b0, 1'b0, 1'b1};
            vectors++;
            if (obs !== exp_v) begin errors++; $display("FAIL stall_hold_%0d got=%h want=%h", i, obs, exp_v); end
            tick();
        end
        bus.stall = 1'b0; #1;
        obs = {bus.next_pc, bus.pc_write, bus.flush, bus.trap_start, bus.busy};
        exp_v = {32'h0000_0300, 1'b1, 1'b0, 1'b0, 1'b1};
        vectors++;
        if (obs !== exp_v) begin errors++; $display("FAIL stall_release got=%h want=%h", obs, exp_v); end
        tick();
        bus.pc = 32'h0000_0300; #1;
        obs = {bus.next_pc, bus.pc_write, bus.flush, bus.trap_start, bus.busy};
        exp_v = {32'h0000_0304, 1'b1, 1'b0, 1'b0, 1'b0};
        vectors++;
        if (obs !== exp_v) begin errors++; $display("FAIL stall_back_run got=%h want=%h", obs, exp_v); end
        tick();
        // New mret in HOLD overwrites the pending branch target
        bus.pc = 32'h0000_0060; bus.stall = 1'b1; bus.br_taken = 1'b1; bus.br_target = 32'h0000_0500;
        tick();
        bus.br_taken = 1'b0; bus.mret_req = 1'b1; bus.mepc = 32'h0000_0601; #1;
        obs = {bus.next_pc, bus.pc_write, bus.flush, bus.trap_start, bus.busy};
        exp_v = {32'h0000_0064, 1'b0, 1'b1, 1'b0, 1'b1};
        vectors++;
        if (obs !== exp_v) begin errors++; $display("FAIL hold_overwrite got=%h want=%h", obs, exp_v); end
        tick(); idle(); #1;
        obs = {bus.next_pc, bus.pc_write, bus.flush, bus.trap_start, bus.busy};
        exp_v = {32'h0000_0600, 1'b1, 1'b0, 1'b0, 1'b1};
        vectors++;
        if (obs !== exp_v) begin errors++; $display("FAIL hold_new_target got=%h want=%h", obs, exp_v); end
        tick();
    endtask

    task automatic test_trap();
        bus.pc = 32'h0000_0400; bus.mtvec = 32'h0000_0200; bus.trap_req = 1'b1; #1;
        obs = {bus.next_pc, bus.pc_write, bus.flush, bus.trap_start, bus.busy};
        exp_v = {32'h0000_0404, 1'b0, 1'b1, 1'b1, 1'b0};
        vectors++;
        if (obs !== exp_v) begin errors++; $display("FAIL trap_enter got=%h want=%h", obs, exp_v); end
        tick();
        bus.trap_req = 1'b0; bus.br_taken = 1'b1; bus.br_target = 32'h0000_0800; #1;
        obs = {bus.next_pc, bus.pc_write, bus.flush, bus.trap_start, bus.busy};
        exp_v = {32'h0000_0404, 1'b0, 1'b1, 1'b0, 1'b1};
        vectors++;
        if (obs !== exp_v) begin errors++; $display("FAIL trap_wait got=%h want=%h", obs, exp_v); end
        tick();
        bus.csr_ack = 1'b1; #1;
        obs = {bus.next_pc, bus.pc_write, bus.flush, bus.trap_start, bus.busy};
        exp_v = {32'h0000_0200, 1'b1, 1'b1, 1'b0, 1'b1};
        vectors++;
        if (obs !== exp_v) begin errors++; $display("FAIL trap_ack got=%h want=%h", obs, exp_v); end
        tick(); idle();
        bus.pc = 32'h0000_0200; #1;
        obs = {bus.next_pc, bus.pc_write, bus.flush, bus.trap_start, bus.busy};
        exp_v = {32'h0000_0204, 1'b1, 1'b0, 1'b0, 1'b0};
        vectors++;
        if (obs !== exp_v) begin errors++; $display("FAIL trap_resume got=%h want=%h", obs, exp_v); end
        tick();
    endtask

    task automatic test_priority();
        bus.pc = 32'h0000_0010; bus.stall = 1'b1; bus.trap_req = 1'b1; bus.mret_req = 1'b1;
        bus.br_taken = 1'b1; bus.csr_ack = 1'b1; bus.mtvec = 32'h0000_0203; #1;
        obs = {bus.next_pc, bus.pc_write, bus.flush, bus.trap_start, bus.busy};
        exp_v = {32'h0000_0014, 1'b0, 1'b1, 1'b1, 1'b0};
        vectors++;
        if (obs !== exp_v) begin errors++; $display("FAIL prio_trap got=%h want=%h", obs, exp_v); end
        tick();
        bus.csr_ack = 1'b0; #1;
        obs = {bus.next_pc, bus.pc_write, bus.flush, bus.trap_start, bus.busy};
        exp_v = {32'h0000_0014, 1'b0, 1'b1, 1'b0, 1'b1};
        vectors++;
        if (obs !== exp_v) begin errors++; $display("FAIL prio_no_retrap got=%h want=%h", obs, exp_v); end
        tick();
        bus.csr_ack = 1'b1; #1;
        obs = {bus.next_pc, bus.pc_write, bus.flush, bus.trap_start, bus.busy};
        exp_v = {32'h0000_0200, 1'b1, 1'b1, 1'b0, 1'b1};
        vectors++;
        if (obs !== exp_v) begin errors++; $display("FAIL prio_ack got=%h want=%h", obs, exp_v); end
        tick(); idle();
        bus.pc = 32'h0000_0200; bus.mret_req = 1'b1; bus.mepc = 32'h0000_0041;
        bus.br_taken = 1'b1; bus.br_target = 32'h0000_0080; #1;
        obs = {bus.next_pc, bus.pc_write, bus.flush, bus.trap_start, bus.busy};
        exp_v = {32'h0000_0040, 1'b1, 1'b1, 1'b0, 1'b0};
        vectors++;
        if (obs !== exp_v) begin errors++; $display("FAIL prio_mret got=%h want=%h", obs, exp_v); end
        tick(); idle();
    endtask

    task automatic test_reset_midflight();
        bus.pc = 32'h0000_0400; bus.trap_req = 1'b1;
        tick(); idle();
        reset = 1'b1; bus.csr_ack = 1'b1; bus.mtvec = 32'h0000_0200; #1;
        obs = {bus.next_pc, bus.pc_write, bus.flush, bus.trap_start, bus.busy};
        exp_v = {32'h0000_0000, 1'b0, 1'b0, 1'b0, 1'b0};
        vectors++;
        if (obs !== exp_v) begin errors++; $display("FAIL rst_trapwait got=%h want=%h", obs, exp_v); end
        tick();
        reset = 1'b0; idle(); bus.pc = 32'h0000_0404; #1;
        obs = {bus.next_pc, bus.pc_write, bus.flush, bus.trap_start, bus.busy};
        exp_v = {32'h0000_0408, 1'b1, 1'b0, 1'b0, 1'b0};
        vectors++;
        if (obs !== exp_v) begin errors++; $display("FAIL rst_trap_release got=%h want=%h", obs, exp_v); end
        tick();
        bus.pc = 32'h0000_0050; bus.stall = 1'b1; bus.br_taken = 1'b1; bus.br_target = 32'h0000_0700;
        tick(); idle();
        reset = 1'b1; bus.stall = 1'b1; #1;
        obs = {bus.next_pc, bus.pc_write, bus.flush, bus.trap_start, bus.busy};
        exp_v = {32'h0000_0000, 1'b0, 1'b0, 1'b0, 1'b0};
        vectors++;
        if (obs !== exp_v) begin errors++; $display("FAIL rst_hold got=%h want=%h", obs, exp_v); end
        tick();
        reset = 1'b0; idle(); bus.pc = 32'h0000_0058; #1;
        obs = {bus.next_pc, bus.pc_write, bus.flush, bus.trap_start, bus.busy};
        exp_v = {32'h0000_005C, 1'b1, 1'b0, 1'b0, 1'b0};
        vectors++;
        if (obs !== exp_v) begin errors++; $display("FAIL rst_hold_release got=%h want=%h", obs, exp_v); end
        tick();
    endtask

    initial begin
        vectors = 0;
        errors  = 0;
        reset   = 1'b1;
        bus.pc  = 32'h0;
        idle();
        test_reset();
        test_sequential();
        test_branch();
        test_branch_stall();
        test_trap();
        test_priority();
        test_reset_midflight();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
